pe_result_collector: RTL

- Downstream of the systolic-array top-level control and its 5-PE row.
- Gathers one result word per PE output event through a valid/ack handshake, with round-robin arbitration across the 5 PEs.
- Buffers accepted results in a small FIFO and writes them sequentially to the output SRAM starting at a base address.
- Tracks the expected result count for a job (rowLen x colTiles x NUM_PE) and pulses done when the last word has been written.

---
 rtl/pe_result_collector.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pe_result_collector.sv
// Gathers PE results under round-robin arbitration, buffers them in a small FIFO
// and streams them to the output SRAM from a base address, pulsing done when the job completes.
module pe_result_collector #(
  parameter int unsigned NUM_PE     = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     start,
  input  logic [7:0]               rowLen,
  input  logic [6:0]               colTiles,
  input  logic [ADDR_W-1:0]        baseAddr,
  input  logic [NUM_PE-1:0]        peValid,
  input  logic [NUM_PE*DATA_W-1:0] peResult,
  output logic [NUM_PE-1:0]        peAck,
  output logic                     wrEn,
  output logic [ADDR_W-1:0]        wrAddr,
  output logic [DATA_W-1:0]        wrData,
  input  logic                     wrReady,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W  = FA_W + 1;
  localparam int unsigned CNT_W = 18;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    expected_q, expected_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [FA_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FA_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FC_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];

  logic [DATA_W-1:0]   pe_word_c [NUM_PE];
  logic [2*NUM_PE-1:0] vv_c;
  logic                found_c;
  logic [PTR_W-1:0]    off_c;
  logic [PTR_W:0]      sum_c;
  logic [PTR_W-1:0]    grant_idx_c;
  logic                eligible_c;
  logic                push_c;
  logic                pop_c;
  logic                fifo_ne_c;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_slice
    assign pe_word_c[g] = peResult[g*DATA_W +: DATA_W];
  end

  // Rotate valids so bit 0 is the PE at rrPtr; lowest set bit is the next grant.
  assign vv_c = {peValid, peValid} >> rr_ptr_q;

  always_comb begin
    found_c = 1'b0;
    off_c   = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (vv_c[k]) begin
        found_c = 1'b1;
        off_c   = PTR_W'(k);
      end
    end
    sum_c       = (PTR_W+1)'(rr_ptr_q) + (PTR_W+1)'(off_c);
    grant_idx_c = (sum_c >= (PTR_W+1)'(NUM_PE)) ? PTR_W'(sum_c - (PTR_W+1)'(NUM_PE))
                                                : PTR_W'(sum_c);
  end

  assign fifo_ne_c  = (fifo_cnt_q != '0);
  assign eligible_c = (state_q == S_COLLECT) && (fifo_cnt_q != FC_W'(FIFO_DEPTH)) &&
                      (acc_cnt_q < expected_q);
  assign push_c     = eligible_c && found_c;
  assign peAck      = push_c ? (NUM_PE'(1) << grant_idx_c) : '0;
  assign busy       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign wrEn       = busy && fifo_ne_c;
  assign pop_c      = wrEn && wrReady;
  assign wrData     = fifo_ne_c ? mem_q[rd_ptr_q] : '0;
  assign wrAddr     = base_q + ADDR_W'(wr_cnt_q);

  // Next-state: FIFO push/pop and counters first, then job sequencing.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    acc_cnt_d  = acc_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    expected_d = expected_q;
    base_d     = base_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    mem_d      = mem_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = pe_word_c[grant_idx_c];
      wr_ptr_d        = wr_ptr_q + FA_W'(1);
      acc_cnt_d       = acc_cnt_q + CNT_W'(1);
      rr_ptr_d        = (grant_idx_c == PTR_W'(NUM_PE - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + FA_W'(1);
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FC_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FC_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          expected_d = CNT_W'(rowLen) * CNT_W'(colTiles) * CNT_W'(NUM_PE);
          base_d     = baseAddr;
          acc_cnt_d  = '0;
          wr_cnt_d   = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          fifo_cnt_d = '0;
          state_d    = (expected_d == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: if (acc_cnt_d == expected_q) state_d = S_DRAIN;
      S_DRAIN:   if (wr_cnt_d == expected_q) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      expected_q <= '0;
      base_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      expected_q <= expected_d;
      base_q     <= base_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule
